// File: rtl/data_memory_lsu_if.sv
// rtl/data_memory_lsu_if.sv - request/response bundle between the datapath and the data memory
interface data_memory_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              ready;
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;
  logic [1:0]        err_cause;

  modport master (
    input  ready, rvalid, rdata, err, err_cause,
    output req, we, size, uns, addr, wdata
  );

  modport slave (
    output ready, rvalid, rdata, err, err_cause,
    input  req, we, size, uns, addr, wdata
  );
endinterface

// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - byte-addressed data memory with sized loads/stores and fault reporting
module data_memory_lsu #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input logic           CLK,
  input logic           RST_N,
  data_memory_lsu_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] hi_bits;
  logic              oor;
  logic              misal;
  logic [1:0]        cause;
  logic [31:0]       word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_val;

  assign accept  = bus.req && bus.ready;
  assign idx     = bus.addr[IDX_W+1:2];
  assign lane    = bus.addr[1:0];
  assign hi_bits = bus.addr >> (IDX_W + 2);
  assign oor     = |hi_bits;
  assign misal   = ((bus.size == 2'b01) && bus.addr[0]) ||
                   ((bus.size == 2'b10) && (lane != 2'b00));

  always_comb begin
    cause = 2'b00;
    if (bus.size == 2'b11)
      cause = 2'b11;
    else if (oor)
      cause = 2'b10;
    else if (misal)
      cause = 2'b01;
  end

  // Read the pre-edge word; a store in the previous cycle has already committed.
  assign word   = mem[idx];
  assign byte_v = word[{lane, 3'b000} +: 8];
  assign half_v = bus.addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = word;
    case (bus.size)
      2'b00:   load_val = bus.uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_val = bus.uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_val = word;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= CLEAR;
      clr_idx       <= '0;
      bus.ready     <= 1'b0;
      bus.rvalid    <= 1'b0;
      bus.rdata     <= 32'b0;
      bus.err       <= 1'b0;
      bus.err_cause <= 2'b00;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
      bus.rvalid    <= accept;
      bus.err       <= accept && (cause != 2'b00);
      bus.err_cause <= accept ? cause : 2'b00;
      bus.rdata     <= (accept && !bus.we && (cause == 2'b00)) ? load_val : 32'b0;
    end
  end

  // Array has no reset; the CLEAR sweep zeroes it one word per cycle.
  always_ff @(posedge CLK) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= 32'b0;
    end else if (accept && bus.we && (cause == 2'b00)) begin
      case (bus.size)
        2'b00:   mem[idx][{lane, 3'b000} +: 8]      <= bus.wdata[7:0];
        2'b01:   mem[idx][{bus.addr[1], 4'b0} +: 16] <= bus.wdata[15:0];
        default: mem[idx]                           <= bus.wdata;
      endcase
    end
  end
endmodule

// File: doc/data_memory_lsu.md
# data_memory_lsu

Parametrised, byte-addressed data memory for the single-cycle/multi-cycle CPU datapath. It replaces the word-indexed data memory. It accepts one load or store request per cycle and supports byte, halfword and word access with sign or zero extension. It flags misaligned, out-of-range and reserved-size accesses, and clears its array with a post-reset sweep so no multi-word reset logic is needed. It sits between the ALU address output and the write-back mux.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DEPTH, 64, number of 32-bit words; power of two, 4..4096; IDX_W = log2(DEPTH)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- ready  out  1  block accepts requests
- req  in  1  request valid
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rvalid  out  1  response valid, one per accepted request
- rdata  out  32  load result; 0 for stores and errored requests
- err  out  1  accepted request faulted (qualified by rvalid)
- err_cause  out  2  00 none, 01 misaligned, 10 out of range, 11 reserved size

## Operation
- FSM states:
  - CLEAR: reset state. clr_idx counts 0..DEPTH-1, writing 0 to mem[clr_idx] each cycle. Moves to IDLE after writing index DEPTH-1.
  - IDLE: ready = 1; serves requests.
- While asserted, reset forces CLEAR, clr_idx = 0, ready = 0, rvalid = 0, rdata = 0, err = 0, err_cause = 00.
- Reset asserted mid-sweep or mid-operation restarts the sweep from index 0. Array contents under reset are don't-care until the sweep completes.
- Acceptance: req && ready at a rising edge. Requests with ready = 0 are ignored: no response, no write.
- Word index = addr[IDX_W+1:2]. Lane = addr[1:0], little-endian: lane 0 = bits [7:0].
- Fault checks, priority order:
  - size = 11 → cause 11
  - any addr bit above IDX_W+1 set → cause 10
  - half with addr[0] = 1, or word with addr[1:0] ≠ 00 → cause 01
- A faulted request causes no memory write. Its response is rvalid = 1, err = 1, rdata = 0.
- Stores write only the addressed lanes: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0}..+1 with wdata[15:0]; SW writes all lanes. Other bytes are unchanged.
- Loads extract the addressed byte/half and extend per uns. Word loads ignore uns.

## Timing
- Sweep length: ready rises exactly DEPTH cycles after the first rising edge with RST_N high.
- Store: the write commits at the accepting edge. Response at the next edge: rvalid = 1, rdata = 0, err per checks.
- Load: synchronous read, latency 1. rdata/rvalid are valid in the cycle after acceptance and held for exactly one cycle. With no request, rvalid = 0 and rdata returns to 0.
- Back-to-back: a request may be accepted every cycle in IDLE. Throughput is 1/cycle.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. No forwarding is needed because the store commits first.
- err and err_cause are valid only while rvalid = 1; otherwise they are 0.

## Test plan
- Reset/sweep, DEPTH = 64: RST_N low 3 cycles, then high → ready = 0 for 64 cycles, then 1. Every LW of 0x00..0xFC returns 0. Assert RST_N at sweep cycle 30 → sweep restarts, ready after a further full 64 cycles.
- Byte lanes: SW 0x11223344 @0x10; SB 0xAA @0x11; SH 0xBEEF @0x12; LW @0x10 → 0xBEEFAA44. LB @0x11 → 0xFFFFFFAA; LBU @0x11 → 0x000000AA; LH @0x12 → 0xFFFFBEEF; LHU @0x12 → 0x0000BEEF.
- Faults:
  - LW @0x06 → err = 1, cause 01, rdata 0.
  - SH @0x05 → cause 01, memory unchanged.
  - LW @0x100 (DEPTH 64) → cause 10.
  - size = 11 @0x101 → cause 11.
- Pipelining: issue SW 0x5 @0x20, LW @0x20, LW @0x24 on consecutive cycles → responses on 3 consecutive cycles: (0, no err), 0x00000005, 0.
- Ignored request: req = 1 during the sweep with SW 0xFFFFFFFF @0x0 → no rvalid; after ready, LW @0x0 → 0.
- Parameter variant DEPTH = 16, ADDR_W = 8: sweep 16 cycles; SW/LW @0x3C round-trips; LW @0x40 → cause 10.
